// File: rtl/buffer_ctrl_pkg.sv
// Shared constants and the buffer-ownership state encoding for the
// USB buffer controller.
package buffer_ctrl_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int OCC_W     = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    U_RECV  = 3'd1,
    H_DRAIN = 3'd2,
    H_FILL  = 3'd3,
    U_SEND  = 3'd4,
    FLUSH   = 3'd5
  } state_t;

endpackage

// File: rtl/buffer_ctrl.sv
// Arbitrates the shared 64-byte USB data buffer between host and USB sides,
// gates store/get strobes against occupancy and tracks packet length/errors.
module buffer_ctrl
  import buffer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             host_wr_req,
  input  logic             host_rd_req,
  input  logic             usb_rx_req,
  input  logic             usb_tx_req,
  input  logic             rx_start,
  input  logic             rx_done,
  input  logic             rx_error,
  input  logic             tx_start,
  input  logic             tx_done,
  input  logic             host_flush,
  output logic             store_tx_data,
  output logic             get_rx_data,
  output logic             store_rx_data,
  output logic             get_tx_data,
  output logic             clear,
  output logic             flush,
  output logic [OCC_W-1:0] rx_len,
  output logic             busy,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(BUF_DEPTH);

  state_t           state;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_inc;

  logic full;
  logic empty;
  logic flush_req;

  logic host_wr_gnt;
  logic host_rd_gnt;
  logic usb_rx_gnt;
  logic usb_tx_gnt;
  logic clear_c;
  logic err_clr;
  logic ovf_set;
  logic udf_set;

  assign full      = buffer_occupancy >= DEPTH;
  assign empty     = buffer_occupancy == '0;
  assign flush_req = host_flush && (state != FLUSH);

  // Length including a byte stored in this very cycle; saturates at capacity.
  assign count_inc = (usb_rx_gnt && (count < DEPTH)) ? count + OCC_W'(1) : count;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    host_wr_gnt = 1'b0;
    host_rd_gnt = 1'b0;
    usb_rx_gnt  = 1'b0;
    usb_tx_gnt  = 1'b0;
    clear_c     = 1'b0;
    err_clr     = 1'b0;
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    if (!flush_req) begin
      case (state)
        IDLE: begin
          clear_c = rx_start;
          err_clr = rx_start;
        end
        U_RECV: begin
          usb_rx_gnt = usb_rx_req && !full;
          ovf_set    = usb_rx_req && full;
        end
        H_DRAIN: begin
          host_rd_gnt = host_rd_req && !empty;
          udf_set     = host_rd_req && empty;
        end
        H_FILL: begin
          host_wr_gnt = host_wr_req && !full;
          ovf_set     = host_wr_req && full;
          err_clr     = tx_start;
        end
        U_SEND: begin
          usb_tx_gnt = usb_tx_req && !empty;
          udf_set    = usb_tx_req && empty;
        end
        default: ;
      endcase
    end
  end

  assign store_tx_data = host_wr_gnt;
  assign get_rx_data   = host_rd_gnt;
  assign store_rx_data = usb_rx_gnt;
  assign get_tx_data   = usb_tx_gnt;
  // State is already IDLE under reset, but rx_start could still leak through.
  assign clear         = clear_c && !rst;
  assign flush         = (state == FLUSH);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rx_len  <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      err_ovf <= (err_ovf && !err_clr) || ovf_set;
      err_udf <= (err_udf && !err_clr) || udf_set;

      if (flush_req) begin
        state <= FLUSH;
      end else begin
        case (state)
          IDLE: begin
            if (rx_start) begin
              state <= U_RECV;
              count <= '0;
            end else if (host_wr_req) begin
              state <= H_FILL;
            end
          end
          U_RECV: begin
            count <= count_inc;
            if (rx_error) begin
              state <= FLUSH;
            end else if (rx_done) begin
              rx_len <= count_inc;
              state  <= (count_inc != '0) ? H_DRAIN : IDLE;
            end
          end
          H_DRAIN: if (empty) state <= IDLE;
          H_FILL:  if (tx_start) state <= U_SEND;
          U_SEND:  if (tx_done) state <= empty ? IDLE : FLUSH;
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Scoreboard bench for buffer_ctrl: a mode-level reference model predicts
// strobes and status; a negedge monitor matches the strobes in order.
module tb_buffer_ctrl;
  import buffer_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] buffer_occupancy;
  logic host_wr_req, host_rd_req, usb_rx_req, usb_tx_req;
  logic rx_start, rx_done, rx_error, tx_start, tx_done, host_flush;
  logic store_tx_data, get_rx_data, store_rx_data, get_tx_data, clear, flush;
  logic [6:0] rx_len;
  logic busy, err_ovf, err_udf;

  buffer_ctrl dut (
    .clk(clk), .rst(rst), .buffer_occupancy(buffer_occupancy),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
    .usb_rx_req(usb_rx_req), .usb_tx_req(usb_tx_req),
    .rx_start(rx_start), .rx_done(rx_done), .rx_error(rx_error),
    .tx_start(tx_start), .tx_done(tx_done), .host_flush(host_flush),
    .store_tx_data(store_tx_data), .get_rx_data(get_rx_data),
    .store_rx_data(store_rx_data), .get_tx_data(get_tx_data),
    .clear(clear), .flush(flush), .rx_len(rx_len), .busy(busy),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic store_tx;
    logic get_rx;
    logic store_rx;
    logic get_tx;
    logic clr;
    logic flsh;
  } ev_t;

  typedef struct {
    int  cyc;
    ev_t ev;
  } exp_t;

  typedef enum {M_IDLE, M_RECV, M_DRAIN, M_FILL, M_SEND, M_FLUSH} mode_t;

  exp_t  sb_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  mode_t m_mode;
  int    m_count, m_rx_len, occ_env;
  bit    m_ovf, m_udf;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t  dv;
    exp_t e;
    if (!rst) begin
      dv = '{store_tx: store_tx_data, get_rx: get_rx_data, store_rx: store_rx_data,
             get_tx: get_tx_data, clr: clear, flsh: flush};
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check("missing_event", 32'(6'(0)), 32'(e.ev));
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check("event", 32'(dv), 32'(e.ev));
      end else if (dv != '0) begin
        check("unexpected_event", 32'(dv), 32'(6'(0)));
      end
    end
  end

  task automatic reset_model();
    m_mode   = M_IDLE;
    m_count  = 0;
    m_rx_len = 0;
    m_ovf    = 0;
    m_udf    = 0;
    occ_env  = 0;
    buffer_occupancy = '0;
  endtask

  task automatic clear_pulses();
    rx_start = 0; rx_done = 0; rx_error = 0;
    tx_start = 0; tx_done = 0; host_flush = 0;
  endtask

  // One clock of stimulus: predict, push expectation, advance, check status.
  task automatic step();
    ev_t   ev;
    mode_t nx;
    bit    full, empty;
    ev    = '0;
    nx    = m_mode;
    full  = occ_env >= BUF_DEPTH;
    empty = occ_env == 0;
    if (m_mode == M_FLUSH) ev.flsh = 1;
    if (host_flush && m_mode != M_FLUSH) begin
      nx = M_FLUSH;
    end else begin
      case (m_mode)
        M_IDLE:
          if (rx_start) begin
            ev.clr = 1; nx = M_RECV; m_count = 0; m_ovf = 0; m_udf = 0;
          end else if (host_wr_req) nx = M_FILL;
        M_RECV: begin
          if (usb_rx_req) begin
            if (!full) begin
              ev.store_rx = 1;
              if (m_count < BUF_DEPTH) m_count++;
            end else m_ovf = 1;
          end
          if (rx_error) nx = M_FLUSH;
          else if (rx_done) begin
            m_rx_len = m_count;
            nx = (m_count > 0) ? M_DRAIN : M_IDLE;
          end
        end
        M_DRAIN: begin
          if (host_rd_req) begin
            if (!empty) ev.get_rx = 1; else m_udf = 1;
          end
          if (empty) nx = M_IDLE;
        end
        M_FILL: begin
          if (tx_start) begin m_ovf = 0; m_udf = 0; nx = M_SEND; end
          if (host_wr_req) begin
            if (!full) ev.store_tx = 1; else m_ovf = 1;
          end
        end
        M_SEND: begin
          if (usb_tx_req) begin
            if (!empty) ev.get_tx = 1; else m_udf = 1;
          end
          if (tx_done) nx = empty ? M_IDLE : M_FLUSH;
        end
        default: nx = M_IDLE;
      endcase
    end
    if (ev != '0) sb_q.push_back('{cyc: cyc, ev: ev});
    m_mode = nx;

    @(posedge clk);
    #1;
    if (ev.clr || ev.flsh) occ_env = 0;
    else occ_env = occ_env + int'(ev.store_tx) + int'(ev.store_rx)
                           - int'(ev.get_rx) - int'(ev.get_tx);
    buffer_occupancy = 7'(occ_env);
    clear_pulses();
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check("rx_len", 32'(rx_len), 32'(m_rx_len));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_udf", 32'(err_udf), 32'(m_udf));
  endtask

  initial begin
    rst = 1;
    host_wr_req = 0; host_rd_req = 0; usb_rx_req = 0; usb_tx_req = 0;
    clear_pulses();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_len", 32'(rx_len), 0);
    check("rst_errs", 32'({err_ovf, err_udf}), 0);
    check("rst_strobes", 32'({store_tx_data, get_rx_data, store_rx_data, get_tx_data, clear, flush}), 0);
    rst = 0;
    @(posedge clk);
    #1;

    // Receive path: 5 bytes, then drain them.
    rx_start = 1; step();
    usb_rx_req = 1; repeat (5) step();
    usb_rx_req = 0; rx_done = 1; step();
    check("rx_len_pkt", 32'(rx_len), 5);
    host_rd_req = 1; repeat (5) step();
    host_rd_req = 0; step();
    check("drain_idle", 32'(busy), 0);

    // Transmit path: 3 writes, commit, 4 reads (last refused), done.
    host_wr_req = 1; repeat (4) step();
    host_wr_req = 0; tx_start = 1; step();
    usb_tx_req = 1; repeat (4) step();
    check("tx_udf", 32'(err_udf), 1);
    usb_tx_req = 0; tx_done = 1; step();
    check("tx_idle", 32'(busy), 0);

    // Overflow during receive; flag survives a flush, clears on rx_start.
    rx_start = 1; step();
    occ_env = BUF_DEPTH; buffer_occupancy = 7'(BUF_DEPTH);
    usb_rx_req = 1; step();
    usb_rx_req = 0; step();
    check("ovf_set", 32'(err_ovf), 1);
    host_flush = 1; step();
    step();
    check("ovf_sticky", 32'(err_ovf), 1);

    // Abort after 10 bytes keeps the previous length.
    rx_start = 1; step();
    check("ovf_cleared", 32'(err_ovf), 0);
    usb_rx_req = 1; repeat (10) step();
    usb_rx_req = 0; rx_error = 1; step();
    step();
    check("abort_rx_len", 32'(rx_len), 5);
    check("abort_idle", 32'(busy), 0);

    // rx_start beats host_wr_req in IDLE.
    rx_start = 1; host_wr_req = 1; step();
    host_wr_req = 0; usb_rx_req = 1; step();
    usb_rx_req = 0; rx_done = 1; step();
    check("prio_rx_len", 32'(rx_len), 1);
    host_rd_req = 1; step();
    host_rd_req = 0; step();

    // host_flush during fill suppresses the grant.
    host_wr_req = 1; step(); step();
    host_flush = 1; step();
    host_wr_req = 0; step();
    check("flush_idle", 32'(busy), 0);

    // Async reset in the middle of a send.
    host_wr_req = 1; repeat (3) step();
    host_wr_req = 0; tx_start = 1; step();
    usb_tx_req = 1;
    #1;
    check("pre_reset_get", 32'(get_tx_data), 1);
    #1 rst = 1;
    #1;
    check("async_strobes", 32'({store_tx_data, get_rx_data, store_rx_data, get_tx_data, clear, flush}), 0);
    check("async_busy", 32'(busy), 0);
    check("async_status", 32'({rx_len, err_ovf, err_udf}), 0);
    usb_tx_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    reset_model();
    step();
    check("post_reset_busy", 32'(busy), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      host_wr_req = 1'($urandom_range(0, 1));
      host_rd_req = 1'($urandom_range(0, 1));
      usb_rx_req  = 1'($urandom_range(0, 1));
      usb_tx_req  = 1'($urandom_range(0, 1));
      rx_start    = ($urandom_range(0, 7) == 0);
      rx_done     = ($urandom_range(0, 15) == 0);
      rx_error    = !rx_done && ($urandom_range(0, 63) == 0);
      tx_start    = ($urandom_range(0, 15) == 0);
      tx_done     = ($urandom_range(0, 15) == 0);
      host_flush  = ($urandom_range(0, 99) == 0);
      step();
    end

    host_wr_req = 0; host_rd_req = 0; usb_rx_req = 0; usb_tx_req = 0;
    repeat (4) step();
    @(posedge clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/buffer_ctrl.md
Name: buffer_ctrl

Overview:
- Sequences and shares the 64-byte USB data buffer between the host-side (AHB slave) requesters and the USB-side (RX/TX packet engine) requesters.
- A mode FSM decides which side owns the buffer: host fill, USB send, USB receive or host drain.
- It gates every store/get strobe against buffer occupancy and issues clear/flush.
- It records received packet length and overflow/underflow errors.

Parameters:
- BUF_DEPTH, 64, buffer capacity in bytes.
- OCC_W, 7, width of occupancy and byte counters; must hold 0..BUF_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- buffer_occupancy  in  7  current byte count from the data buffer.
- host_wr_req  in  1  host wants to write one TX byte.
- host_rd_req  in  1  host wants to read one RX byte.
- usb_rx_req  in  1  USB receiver has one byte to store.
- usb_tx_req  in  1  USB transmitter wants one byte.
- rx_start  in  1  pulse: receiver detected a data packet.
- rx_done  in  1  pulse: packet ended, CRC good.
- rx_error  in  1  pulse: packet aborted or bad CRC.
- tx_start  in  1  pulse: host commits the filled buffer for transmission.
- tx_done  in  1  pulse: transmitter finished the packet.
- host_flush  in  1  pulse: host requests buffer flush.
- store_tx_data  out  1  buffer strobe; equals host_wr_gnt.
- get_rx_data  out  1  buffer strobe; equals host_rd_gnt.
- store_rx_data  out  1  buffer strobe; equals usb_rx_gnt.
- get_tx_data  out  1  buffer strobe; equals usb_tx_gnt.
- clear  out  1  one-cycle buffer clear.
- flush  out  1  one-cycle buffer flush.
- rx_len  out  7  byte count of the last good received packet.
- busy  out  1  state != IDLE.
- err_ovf  out  1  sticky: a store was refused because the buffer was full.
- err_udf  out  1  sticky: a get was refused because the buffer was empty.

Behaviour:
- Reset (async, rst=1) puts the FSM in IDLE. All strobes and clear/flush are 0. rx_len=0. err_ovf=0 and err_udf=0. The byte counter is 0.
- Reset mid-packet abandons the transfer with no flush pulse. The buffer has its own reset.
- Grants are combinational from the current state, the request and buffer_occupancy. There is at most one grant per cycle. Occupancy reflects a strobe on the following cycle.
- Store is granted only when occupancy < BUF_DEPTH. Get is granted only when occupancy > 0.
- A refused store in the owning state sets err_ovf. A refused get in the owning state sets err_udf.
- Requests from the non-owning side are ignored silently, with no error.
- Data timing: host read data is valid in the grant cycle. USB TX data is valid the cycle after usb_tx_gnt.
- FSM states and transitions:
  - IDLE:
    - rx_start → U_RECV, with clear=1 in the transition cycle and the byte counter zeroed.
    - Otherwise, host_wr_req → H_FILL; the first write is granted in the next cycle.
    - rx_start has priority over host_wr_req.
  - U_RECV:
    - Grant usb_rx_req and count stored bytes.
    - rx_done → capture rx_len=count (plus 1 if a store is granted in the same cycle). Then go to H_DRAIN if the captured length > 0, otherwise to IDLE.
    - rx_error → FLUSH.
  - H_DRAIN:
    - Grant host_rd_req.
    - Go to IDLE in the cycle after the last byte is taken (occupancy==0, no grant).
  - H_FILL:
    - Grant host_wr_req.
    - tx_start → U_SEND; if host_wr_req is also high, that final write is granted.
  - U_SEND:
    - Grant usb_tx_req.
    - tx_done → FLUSH if occupancy > 0, otherwise IDLE.
  - FLUSH: flush=1 for exactly one cycle, then IDLE.
- host_flush in any state except FLUSH forces FLUSH and has top priority. No grant is issued in that cycle.
- Sticky error flags clear on the rx_start or tx_start transition and on reset.
- The byte counter saturates at BUF_DEPTH; it does not wrap.

Decomposition:
- Package buffer_ctrl_pkg holds:
  - the state enum (IDLE, U_RECV, H_DRAIN, H_FILL, U_SEND, FLUSH), 3-bit logic;
  - the BUF_DEPTH and OCC_W constants.
- Single module; no natural sub-module.

Test Plan:
- Receive path: rx_start, 5 usb_rx_req bytes, rx_done → clear for 1 cycle, 5 store_rx_data pulses, rx_len=5, state H_DRAIN. Five host_rd_req → 5 get_rx_data, then IDLE with busy=0.
- Transmit path: 3 host_wr_req, tx_start, usb_tx_req held → 3 store_tx_data, then exactly 3 get_tx_data. A 4th usb_tx_req is refused and err_udf=1. tx_done with occupancy 0 → IDLE, no flush.
- Overflow: in U_RECV with buffer_occupancy=64, assert usb_rx_req → no store_rx_data, err_ovf=1. The flag persists until the next rx_start.
- Abort: rx_error after 10 bytes → one flush pulse, then IDLE, rx_len unchanged from the previous packet.
- Priority and flush: rx_start and host_wr_req together in IDLE → U_RECV. host_flush during H_FILL with host_wr_req high → no grant, flush=1 next cycle, then IDLE.
- Async reset: assert rst mid-U_SEND between clock edges → all outputs 0 immediately, and state is IDLE after release.
